// File: rtl/cdc_hs_defines.sv
// Shared definitions for the req/ack four-phase CDC handshake (tx and rx ends).
// Holds the FSM state width/encoding and the default ack/req synchronizer depth.
// No logic; imported by cdc_hs_ack_sync and cdc_hs_tx.
package cdc_hs_defines;

  localparam int CDC_HS_STATE_W     = 2;
  localparam int CDC_HS_SYNC_DP_DEF = 2;

  // Encoding 3 is illegal and is steered back to IDLE by the FSM.
  typedef enum logic [CDC_HS_STATE_W-1:0] {
    CDC_HS_IDLE    = 2'd0,
    CDC_HS_REQ     = 2'd1,
    CDC_HS_WAIT_LO = 2'd2
  } cdc_hs_state_e;

endpackage

// File: rtl/cdc_hs_ack_sync.sv
// 1-bit multi-flop level synchronizer, reset to 0; shared by the tx (ack) and rx (req) ends.
// Latency: an edge on d_i appears on q_o SYNC_DP clk edges later.
// Backpressure: none, free-running level path.
// Ports: clk, rst (async, active-high), d_i (asynchronous level), q_o (synchronized level).
module cdc_hs_ack_sync
  import cdc_hs_defines::*;
#(
  parameter int SYNC_DP = CDC_HS_SYNC_DP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DP-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DP-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_DP-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit end of a four-phase req/ack CDC handshake: takes one word over valid/ready, holds it on data_o under req_o.
// Latency: accept -> req_o next cycle; ack_i rise -> req_o fall and ack_i fall -> done_o each SYNC_DP+1 edges.
// Backpressure: src_ready_o only in IDLE with synchronized ack low; no buffering, source must hold valid.
// Ports: clk/rst (async active-high); src_valid_i/src_data_i/src_ready_o local side;
//        req_o/data_o/ack_i remote side; done_o completion pulse; tmo_o abort pulse.
// Optional: define CDC_HS_TX_TIMEOUT_EN to abort a stuck transfer after 2**TMO_W-1 busy cycles.
module cdc_hs_tx
  import cdc_hs_defines::*;
#(
  parameter int DW      = 32,
  parameter int SYNC_DP = CDC_HS_SYNC_DP_DEF,
  parameter int TMO_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_valid_i,
  input  logic [DW-1:0] src_data_i,
  output logic          src_ready_o,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          ack_i,
  output logic          done_o,
  output logic          tmo_o
);

  cdc_hs_state_e  state_q;
  logic           req_q;
  logic           done_q;
  logic [DW-1:0]  data_q;
  logic           ack_s;
  logic           accept;
  logic           tmo_hit;

  cdc_hs_ack_sync #(.SYNC_DP(SYNC_DP)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_i),
    .q_o (ack_s)
  );

  // A stale high ack (e.g. remote reset while we were idle) must drain before a new accept.
  assign src_ready_o = (state_q == CDC_HS_IDLE) && !ack_s;
  assign accept      = src_valid_i && src_ready_o;

`ifdef CDC_HS_TX_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;
  logic             tmo_q;
  logic             busy;
  logic             advance;

  assign busy    = (state_q == CDC_HS_REQ) || (state_q == CDC_HS_WAIT_LO);
  assign advance = ((state_q == CDC_HS_REQ) && ack_s) ||
                   ((state_q == CDC_HS_WAIT_LO) && !ack_s);
  assign cnt_d   = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
  // Abort on the edge the count would reach all-ones; a legal handshake step wins a tie.
  assign tmo_hit = busy && !advance && (&cnt_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (accept || ((state_q == CDC_HS_REQ) && ack_s)) begin
        cnt_q <= '0;
      end else if (busy) begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign tmo_o = tmo_q;
`else
  logic [TMO_W-1:0] unused_tmo_w;
  assign unused_tmo_w = '0;
  assign tmo_hit      = 1'b0;
  assign tmo_o        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CDC_HS_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CDC_HS_IDLE: begin
          if (accept) begin
            data_q  <= src_data_i;
            req_q   <= 1'b1;
            state_q <= CDC_HS_REQ;
          end
        end
        CDC_HS_REQ: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= CDC_HS_WAIT_LO;
          end
        end
        CDC_HS_WAIT_LO: begin
          if (!ack_s) begin
            done_q  <= 1'b1;
            state_q <= CDC_HS_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= CDC_HS_IDLE;
        end
      endcase
      if (tmo_hit) begin
        req_q   <= 1'b0;
        state_q <= CDC_HS_IDLE;
      end
    end
  end

  assign req_o  = req_q;
  assign data_o = data_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Scoreboard bench for cdc_hs_tx: stimulus pushes expected req/done/tmo events with their cycle,
// a monitor sampling 2 time units after each rising edge pops and compares them.
// Tie-breaking order inside one sample: RISE, FALL, TMO, DONE.
module tb_cdc_hs_tx;

  localparam int DW = 32;
`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int TB_TMO_W = 4;
`else
  localparam int TB_TMO_W = 16;
`endif

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_TMO  = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int            kind;
    logic [DW-1:0] dat;
    int            cyc;
  } ev_t;

  logic          clk;
  logic          rst;
  logic          src_valid_i;
  logic [DW-1:0] src_data_i;
  logic          src_ready_o;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          ack_i;
  logic          done_o;
  logic          tmo_o;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];

  cdc_hs_tx #(.DW(DW), .SYNC_DP(2), .TMO_W(TB_TMO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid_i (src_valid_i),
    .src_data_i  (src_data_i),
    .src_ready_o (src_ready_o),
    .req_o       (req_o),
    .data_o      (data_o),
    .ack_i       (ack_i),
    .done_o      (done_o),
    .tmo_o       (tmo_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [DW-1:0] dat, input int c);
    ev_t e;
    e.kind = kind;
    e.dat  = dat;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [DW-1:0] dat);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d data 0x%08h at cyc %0d, want none", kind, dat, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.dat !== dat || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event: got kind %0d data 0x%08h cyc %0d, want kind %0d data 0x%08h cyc %0d",
                 kind, dat, cyc, e.kind, e.dat, e.cyc);
      end
    end
  endtask

  // Monitor
  initial begin
    logic          req_prev;
    logic [DW-1:0] held;
    req_prev = 1'b0;
    held     = '0;
    forever begin
      @(posedge clk);
      #2;
      if (req_o && !req_prev) begin
        got(EV_RISE, data_o);
        held = data_o;
      end
      if (!req_o && req_prev) got(EV_FALL, data_o);
      if (tmo_o) got(EV_TMO, data_o);
      if (done_o) got(EV_DONE, data_o);
      if (req_o && req_prev) chk("data_hold", data_o, held);
      req_prev = req_o;
    end
  end

  // One full transfer with a remote raising ack ack_dly cycles after req_o and dropping it
  // drop_dly cycles after req_o falls. With hold=1, valid stays high carrying nd afterwards.
  task automatic xfer(input logic [DW-1:0] d, input int ack_dly, input int drop_dly,
                      input bit hold, input logic [DW-1:0] nd);
    int t;
    int k;
    k = 0;
    while (!src_ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {31'd0, src_ready_o}, 32'd1);
    src_valid_i = 1'b1;
    src_data_i  = d;
    t = cyc;
    push(EV_RISE, d, t + 1);
    push(EV_FALL, d, t + 4 + ack_dly);
    push(EV_DONE, d, t + 7 + ack_dly + drop_dly);
    @(negedge clk);
    if (hold) src_data_i = nd;
    else      src_valid_i = 1'b0;
    repeat (ack_dly) @(negedge clk);
    ack_i = 1'b1;
    repeat (3 + drop_dly) @(negedge clk);
    ack_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t;
    int c;
    rst         = 1'b0;
    ack_i       = 1'b0;
    src_valid_i = 1'b0;
    src_data_i  = '0;
    #1 rst = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, req_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_tmo", {31'd0, tmo_o}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", {31'd0, src_ready_o}, 32'd1);
    chk("post_rst_req", {31'd0, req_o}, 32'd0);
    chk("post_rst_data", data_o, 32'd0);

    // Basic transfer, remote 3/3
    xfer(32'hDEADBEEF, 3, 3, 1'b0, '0);

    // Back-to-back with valid held across both words
    xfer(32'h11111111, 3, 3, 1'b1, 32'h22222222);
    xfer(32'h22222222, 2, 1, 1'b0, '0);
    chk("b2b_ready_after", {31'd0, src_ready_o}, 32'd1);

    // Reset while in REQ
    src_valid_i = 1'b1;
    src_data_i  = 32'hCAFEF00D;
    t = cyc;
    push(EV_RISE, 32'hCAFEF00D, t + 1);
    @(negedge clk);
    src_valid_i = 1'b0;
    chk("pre_rst_req", {31'd0, req_o}, 32'd1);
    push(EV_FALL, 32'd0, t + 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, req_o}, 32'd0);
    chk("mid_rst_data", data_o, 32'd0);
    chk("mid_rst_idle", {31'd0, src_ready_o}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    xfer(32'h0BADF00D, 1, 0, 1'b0, '0);

    // Stale ack held high through reset release
    ack_i = 1'b1;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_ready_lo", {31'd0, src_ready_o}, 32'd0);
    ack_i = 1'b0;
    @(negedge clk);
    chk("stale_ready_still_lo", {31'd0, src_ready_o}, 32'd0);
    @(negedge clk);
    chk("stale_ready_hi", {31'd0, src_ready_o}, 32'd1);

`ifdef CDC_HS_TX_TIMEOUT_EN
    // Remote never answers: abort 15 cycles after REQ entry
    src_valid_i = 1'b1;
    src_data_i  = 32'hA5A5A5A5;
    c = cyc;
    push(EV_RISE, 32'hA5A5A5A5, c + 1);
    push(EV_FALL, 32'hA5A5A5A5, c + 16);
    push(EV_TMO,  32'hA5A5A5A5, c + 16);
    @(negedge clk);
    src_valid_i = 1'b0;
    repeat (15) @(negedge clk);
    chk("tmo_req_lo", {31'd0, req_o}, 32'd0);
    @(negedge clk);
    chk("tmo_ready_next", {31'd0, src_ready_o}, 32'd1);
`else
    c = 0;
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish before it");
    $fatal(1, "watchdog");
  end

endmodule
